// File: rtl/slow_mult_pipeline_pkg.sv
// Shared constants and helpers for the pipelined shift-and-add multiplier.
//   default_wordsize : operand width used when the parent does not override it
//   min_wordsize     : smallest operand width the pipeline structure supports
//   stage_count()    : number of register stages for a given operand width
package slow_mult_pipeline_pkg;

  localparam int unsigned default_wordsize = 16;
  localparam int unsigned min_wordsize     = 2;

  // Each operand bit except the last is retired by one register stage.
  // The last partial product is folded into the combinational output add.
  function automatic int unsigned stage_count(input int unsigned wordsize);
    return wordsize - 1;
  endfunction

endpackage

// File: rtl/slow_mult_pipeline_stage.sv
// One shift-and-add stage of the multiplier pipeline.
// The stage adds the partial product selected by the low multiplier bit
// of the previous stage, then shifts the operands for the next stage.
// Ports:
//   clk             : rising-edge clock
//   reset           : asynchronous active-low clear of all stage registers
//   enable          : stage advances only when high, otherwise holds
//   in_1_shift_prev : shifted multiplicand from the previous stage (2*wordsize)
//   in_2_shift_prev : shifted multiplier from the previous stage (wordsize)
//   tmp_result_prev : accumulated partial sum from the previous stage (2*wordsize)
//   in_1_shift      : registered multiplicand, shifted left by one
//   in_2_shift      : registered multiplier, shifted right by one
//   tmp_result      : registered accumulated partial sum
module slow_mult_pipeline_stage #(
  parameter int unsigned wordsize = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [2*wordsize-1:0]   in_1_shift_prev,
  input  logic [wordsize-1:0]     in_2_shift_prev,
  input  logic [2*wordsize-1:0]   tmp_result_prev,
  output logic [2*wordsize-1:0]   in_1_shift,
  output logic [wordsize-1:0]     in_2_shift,
  output logic [2*wordsize-1:0]   tmp_result
);

  logic [2*wordsize-1:0] partial;

  assign partial = in_2_shift_prev[0] ? in_1_shift_prev : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_1_shift <= '0;
      in_2_shift <= '0;
      tmp_result <= '0;
    end else if (enable) begin
      in_1_shift <= in_1_shift_prev << 1;
      in_2_shift <= in_2_shift_prev >> 1;
      tmp_result <= tmp_result_prev + partial;
    end
  end

endmodule

// File: rtl/slow_mult_pipeline.sv
// Pipelined unsigned shift-and-add multiplier: one adder per stage, one new
// operand pair accepted on every enabled edge. The product of operands
// sampled at enabled edge k is visible on out after enabled edge k+N-1,
// where N = wordsize-1 is the number of register stages.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-low clear of every pipeline register
//   enable : pipeline advance; all registers hold while low
//   in_1   : multiplicand, unsigned (wordsize bits)
//   in_2   : multiplier, unsigned (wordsize bits)
//   out    : unsigned product (2*wordsize bits), combinational from last stage
module slow_mult_pipeline
  import slow_mult_pipeline_pkg::*;
#(
  parameter int unsigned wordsize = default_wordsize
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [wordsize-1:0]     in_1,
  input  logic [wordsize-1:0]     in_2,
  output logic [2*wordsize-1:0]   out
);

  localparam int unsigned n_stages = stage_count(wordsize);

  // Stage-indexed views of the pipeline; every element is driven by exactly
  // one continuous source (stage 0 registers or a stage instance).
  logic [2*wordsize-1:0] in_1_shift [n_stages];
  logic [wordsize-1:0]   in_2_shift [n_stages];
  logic [2*wordsize-1:0] tmp_result [n_stages];

  logic [2*wordsize-1:0] in_1_ext;
  logic [2*wordsize-1:0] s0_in_1_shift;
  logic [wordsize-1:0]   s0_in_2_shift;
  logic [2*wordsize-1:0] s0_tmp_result;

  assign in_1_ext = {{wordsize{1'b0}}, in_1};

  // NOTE: the reset branch sits in the sensitivity list so clearing happens
  // immediately, and all state is written with <= so every register sees
  // the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0_in_1_shift <= '0;
      s0_in_2_shift <= '0;
      s0_tmp_result <= '0;
    end else if (enable) begin
      s0_in_1_shift <= in_1_ext << 1;
      s0_in_2_shift <= in_2 >> 1;
      s0_tmp_result <= in_2[0] ? in_1_ext : '0;
    end
  end

  assign in_1_shift[0] = s0_in_1_shift;
  assign in_2_shift[0] = s0_in_2_shift;
  assign tmp_result[0] = s0_tmp_result;

  // Stages 1..N-1; the loop is empty when wordsize is 2.
  for (genvar i = 1; i < n_stages; i++) begin : g_stage
    slow_mult_pipeline_stage #(
      .wordsize (wordsize)
    ) u_stage (
      .clk             (clk),
      .reset           (reset),
      .enable          (enable),
      .in_1_shift_prev (in_1_shift[i-1]),
      .in_2_shift_prev (in_2_shift[i-1]),
      .tmp_result_prev (tmp_result[i-1]),
      .in_1_shift      (in_1_shift[i]),
      .in_2_shift      (in_2_shift[i]),
      .tmp_result      (tmp_result[i])
    );
  end

  // The final partial product is added combinationally so latency is N
  // enabled edges rather than N+1.
  assign out = tmp_result[n_stages-1]
             + (in_2_shift[n_stages-1][0] ? in_1_shift[n_stages-1] : '0);

endmodule

// File: tb/tb_slow_mult_pipeline.sv
// Directed self-checking bench for slow_mult_pipeline at wordsize 6
// (5 register stages, product visible after the 5th enabled edge).
module tb_slow_mult_pipeline;

  localparam int unsigned ws  = 6;
  localparam int unsigned lat = ws - 1;

  logic            clk;
  logic            reset;
  logic            enable;
  logic [ws-1:0]   in_1;
  logic [ws-1:0]   in_2;
  logic [2*ws-1:0] prod;

  int n_total = 0;
  int n_bad   = 0;

  slow_mult_pipeline #(
    .wordsize (ws)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .in_1   (in_1),
    .in_2   (in_2),
    .out    (prod)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2*ws-1:0] obs,
                       input logic [2*ws-1:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [ws-1:0]   a;
    logic [ws-1:0]   b;
    logic [2*ws-1:0] p;
  } vec_t;

  vec_t extremes [4];

  initial begin
    extremes[0] = '{a: 6'd63, b: 6'd63, p: 12'd3969};
    extremes[1] = '{a: 6'd0,  b: 6'd63, p: 12'd0};
    extremes[2] = '{a: 6'd63, b: 6'd1,  p: 12'd63};
    extremes[3] = '{a: 6'd32, b: 6'd2,  p: 12'd64};

    reset  = 1'b0;
    enable = 1'b1;
    in_1   = '0;
    in_2   = '0;
    #1;
    check("reset_state", prod, 12'd0);

    // 1 * 10 with reset pulsed first
    in_1 = 6'd1;
    in_2 = 6'd10;
    tick();
    tick();
    check("during_reset", prod, 12'd0);
    #2 reset = 1'b1;
    for (int e = 1; e < lat; e++) begin
      tick();
      check($sformatf("fill_1x10_e%0d", e), prod, 12'd0);
    end
    tick();
    check("1x10", prod, 12'd10);

    // 10 * 12 held for 10 cycles
    in_1 = 6'd10;
    in_2 = 6'd12;
    for (int e = 1; e < lat; e++) begin
      tick();
      check($sformatf("hold_prev_e%0d", e), prod, 12'd10);
    end
    tick();
    check("10x12", prod, 12'd120);
    for (int e = 0; e < 5; e++) begin
      tick();
      check($sformatf("10x12_stable%0d", e), prod, 12'd120);
    end

    // back-to-back: 60*40 for one cycle, then 10*10
    in_1 = 6'd60;
    in_2 = 6'd40;
    tick();
    in_1 = 6'd10;
    in_2 = 6'd10;
    tick();
    tick();
    tick();
    check("b2b_before", prod, 12'd120);
    tick();
    check("b2b_60x40", prod, 12'd2400);
    tick();
    check("b2b_10x10", prod, 12'd100);

    // extremes, each after full latency
    foreach (extremes[k]) begin
      in_1 = extremes[k].a;
      in_2 = extremes[k].b;
      for (int e = 0; e < lat; e++) tick();
      check($sformatf("extreme_%0dx%0d", extremes[k].a, extremes[k].b),
            prod, extremes[k].p);
    end

    // stall at the pipeline midpoint; inputs changed during stall are ignored
    in_1 = 6'd7;
    in_2 = 6'd9;
    tick();
    tick();
    enable = 1'b0;
    in_1   = 6'd0;
    in_2   = 6'd0;
    for (int e = 0; e < 3; e++) begin
      tick();
      check($sformatf("stall_hold%0d", e), prod, 12'd64);
    end
    in_1   = 6'd7;
    in_2   = 6'd9;
    enable = 1'b1;
    tick();
    tick();
    check("stall_not_early", prod, 12'd64);
    tick();
    check("stall_7x9", prod, 12'd63);

    // reset mid-flight discards 5*5
    in_1 = 6'd5;
    in_2 = 6'd5;
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    check("async_reset_clear", prod, 12'd0);
    in_1 = 6'd3;
    in_2 = 6'd4;
    tick();
    check("reset_held", prod, 12'd0);
    #2 reset = 1'b1;
    for (int e = 1; e < lat; e++) begin
      tick();
      check($sformatf("no_25_e%0d", e), prod, 12'd0);
    end
    tick();
    check("3x4_after_reset", prod, 12'd12);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
